// File: rtl/wb_regfile_if.sv
// MEM/WB-to-writeback bundle plus the two ID-stage read ports of the register file.
// Bypass lets ID read, in the same cycle, the value WB is about to commit.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // Writeback has no handshake: RegWrite is a per-cycle qualifier.
  // Data is taken on every rising clock edge where RegWrite=1 and Dest!=0.
  // The register file never stalls the pipeline.
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] link_addr;
  logic [ADDR_W-1:0] Dest;
  logic              RegWrite;
  logic              Jump;
  logic              MemtoReg;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic              wb_en;
  logic [31:0]       wb_count;

  modport master (
    output read_data, alu_result, link_addr, Dest, RegWrite, Jump, MemtoReg,
    output rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_en, wb_count
  );

  modport slave (
    input  read_data, alu_result, link_addr, Dest, RegWrite, Jump, MemtoReg,
    input  rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_en, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and 32-entry architectural register file.
// Read ports bypass the write being committed in the same cycle.
module wb_regfile #(
  parameter int                 DATA_W     = 32,
  parameter int                 ADDR_W     = 5,
  parameter logic [DATA_W-1:0]  SP_INIT    = '0,
  // Reset value of the commit counter; normally 0.
  parameter logic [31:0]        COUNT_INIT = '0
) (
  input  logic       clk,
  input  logic       rst,
  wb_regfile_if.slave bus
);

  localparam int NREGS  = 2 ** ADDR_W;
  localparam int SP_IDX = 29;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [31:0]       wb_count_q;
  logic [31:0]       wb_count_d;

  logic [DATA_W-1:0] wb_data;
  logic              wb_en;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  // Jump outranks MemtoReg so jump-and-link always writes the return address.
  always_comb begin
    wb_data = bus.alu_result;
    if (bus.Jump) begin
      wb_data = bus.link_addr;
    end else if (bus.MemtoReg) begin
      wb_data = bus.read_data;
    end
  end

  assign wb_en = bus.RegWrite && (bus.Dest != '0) && !rst;

  always_comb begin
    regs_d     = regs_q;
    wb_count_d = wb_count_q;
    if (wb_en) begin
      regs_d[bus.Dest] = wb_data;
      wb_count_d       = wb_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
      wb_count_q <= COUNT_INIT;
    end else begin
      regs_q     <= regs_d;
      wb_count_q <= wb_count_d;
    end
  end

  // Each port bypasses independently, so rs==rt==Dest forwards on both.
  always_comb begin
    rs_data = regs_q[bus.rs_addr];
    if (bus.rs_addr == '0) begin
      rs_data = '0;
    end else if (wb_en && (bus.rs_addr == bus.Dest)) begin
      rs_data = wb_data;
    end
  end

  always_comb begin
    rt_data = regs_q[bus.rt_addr];
    if (bus.rt_addr == '0) begin
      rt_data = '0;
    end else if (wb_en && (bus.rt_addr == bus.Dest)) begin
      rt_data = wb_data;
    end
  end

  assign bus.rs_data  = rs_data;
  assign bus.rt_data  = rt_data;
  assign bus.wb_data  = wb_data;
  assign bus.wb_en    = wb_en;
  assign bus.wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset values, mux priority, bypass, r0 handling,
// reset-wins-over-write and commit counter wrap.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .SP_INIT(32'h0000_7FFC)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  // Second instance starts its counter at the top of range to reach the wrap.
  wb_regfile #(.DATA_W(32), .ADDR_W(5), .SP_INIT(32'h0), .COUNT_INIT(32'hFFFF_FFFF)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs set afterwards apply to the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic rw, input logic [4:0] dest, input logic jmp,
                          input logic m2r, input logic [31:0] alu,
                          input logic [31:0] rd, input logic [31:0] link);
    bus0.RegWrite   = rw;
    bus0.Dest       = dest;
    bus0.Jump       = jmp;
    bus0.MemtoReg   = m2r;
    bus0.alu_result = alu;
    bus0.read_data  = rd;
    bus0.link_addr  = link;
  endtask

  task automatic drive_rd(input logic [4:0] rs, input logic [4:0] rt);
    bus0.rs_addr = rs;
    bus0.rt_addr = rt;
    #1;
  endtask

  initial begin
    drive_wb(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    drive_rd(5'd0, 5'd0);
    bus1.RegWrite   = 1'b0;
    bus1.Dest       = 5'd1;
    bus1.Jump       = 1'b0;
    bus1.MemtoReg   = 1'b0;
    bus1.alu_result = 32'h5;
    bus1.read_data  = 32'h0;
    bus1.link_addr  = 32'h0;
    bus1.rs_addr    = 5'd1;
    bus1.rt_addr    = 5'd0;

    // Reset values
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_rd(5'd29, 5'd5);
    check("reset_sp", bus0.rs_data, 32'h0000_7FFC);
    check("reset_r5", bus0.rt_data, 32'h0);
    check("reset_count", bus0.wb_count, 32'h0);
    check("idle_wb_en", {31'b0, bus0.wb_en}, 32'h0);

    // ALU writeback with same-cycle bypass on both ports
    drive_wb(1'b1, 5'd8, 1'b0, 1'b0, 32'h1234, 32'h9999, 32'h8888);
    drive_rd(5'd8, 5'd8);
    check("alu_wb_data", bus0.wb_data, 32'h1234);
    check("alu_wb_en", {31'b0, bus0.wb_en}, 32'h1);
    check("bypass_rs", bus0.rs_data, 32'h1234);
    check("bypass_rt", bus0.rt_data, 32'h1234);
    tick();
    drive_wb(1'b0, 5'd8, 1'b0, 1'b0, 32'hDEAD, 32'h9999, 32'h8888);
    drive_rd(5'd8, 5'd9);
    check("stored_r8", bus0.rs_data, 32'h1234);
    check("no_bypass_when_idle", bus0.rt_data, 32'h0);
    check("mux_idle_alu", bus0.wb_data, 32'hDEAD);
    check("count_one", bus0.wb_count, 32'h1);

    // Write to r0 is dropped
    drive_wb(1'b1, 5'd0, 1'b0, 1'b0, 32'hFFFF, 32'h0, 32'h0);
    drive_rd(5'd0, 5'd0);
    check("r0_wb_en", {31'b0, bus0.wb_en}, 32'h0);
    check("r0_rs_bypass", bus0.rs_data, 32'h0);
    tick();
    drive_wb(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    drive_rd(5'd0, 5'd8);
    check("r0_read", bus0.rs_data, 32'h0);
    check("r0_count", bus0.wb_count, 32'h1);
    check("r8_kept", bus0.rt_data, 32'h1234);

    // Jump wins over MemtoReg; then MemtoReg alone
    drive_wb(1'b1, 5'd31, 1'b1, 1'b1, 32'h55, 32'hAA, 32'h400);
    drive_rd(5'd31, 5'd8);
    check("jump_priority", bus0.wb_data, 32'h400);
    tick();
    drive_wb(1'b1, 5'd30, 1'b0, 1'b1, 32'h55, 32'hAA, 32'h400);
    drive_rd(5'd1, 5'd30);
    check("mem_select", bus0.wb_data, 32'hAA);
    check("bypass_rt_only", bus0.rt_data, 32'hAA);
    check("rs_unrelated", bus0.rs_data, 32'h0);
    tick();
    drive_wb(1'b0, 5'd30, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    drive_rd(5'd31, 5'd30);
    check("r31_link", bus0.rs_data, 32'h400);
    check("r30_load", bus0.rt_data, 32'hAA);
    check("count_three", bus0.wb_count, 32'h3);

    // $sp is an ordinary writable register after reset
    drive_wb(1'b1, 5'd29, 1'b0, 1'b0, 32'hCAFE_0000, 32'h0, 32'h0);
    tick();
    drive_wb(1'b0, 5'd29, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    drive_rd(5'd29, 5'd31);
    check("sp_written", bus0.rs_data, 32'hCAFE_0000);

    // Reset wins over a same-cycle write; the repeated write commits afterwards
    rst = 1'b1;
    drive_wb(1'b1, 5'd3, 1'b0, 1'b0, 32'h7, 32'h0, 32'h0);
    drive_rd(5'd3, 5'd29);
    check("rst_wb_en", {31'b0, bus0.wb_en}, 32'h0);
    tick();
    rst = 1'b0;
    drive_rd(5'd3, 5'd8);
    check("post_rst_bypass", bus0.rs_data, 32'h7);
    check("post_rst_count", bus0.wb_count, 32'h0);
    check("post_rst_r8", bus0.rt_data, 32'h0);
    drive_rd(5'd3, 5'd29);
    check("post_rst_sp", bus0.rt_data, 32'h0000_7FFC);
    drive_wb(1'b0, 5'd3, 1'b0, 1'b0, 32'h7, 32'h0, 32'h0);
    drive_rd(5'd3, 5'd29);
    check("lost_write_r3", bus0.rs_data, 32'h0);
    drive_wb(1'b1, 5'd3, 1'b0, 1'b0, 32'h7, 32'h0, 32'h0);
    tick();
    drive_wb(1'b0, 5'd3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    drive_rd(5'd3, 5'd31);
    check("r3_committed", bus0.rs_data, 32'h7);
    check("r31_cleared", bus0.rt_data, 32'h0);
    check("count_after_rst", bus0.wb_count, 32'h1);

    // Counter wrap from 0xFFFFFFFF
    check("wrap_start", bus1.wb_count, 32'hFFFF_FFFF);
    bus1.RegWrite = 1'b1;
    tick();
    bus1.RegWrite = 1'b0;
    #1;
    check("wrap_zero", bus1.wb_count, 32'h0);
    check("wrap_r1", bus1.rs_data, 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
